regfile_sequencer: RTL

- Multi-cycle controller that owns all `register_file` control ports: selects, read enables, write enable, write data and PSR write.
- Accepts one decoded operation per handshake and runs READ → CAPTURE → EXEC → WRITE.
- Presents registered operands to the ALU and writes the result and flags back.
- Sits between decode and `register_file`; the ALU is external.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/regfile_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file select codes and sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] REG_PSTACK = 4'hF;
  localparam logic [3:0] REG_RSTACK = 4'hE;
  localparam logic [3:0] REG_PSR    = 4'hD;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;

  function automatic logic is_stack(input logic [3:0] sel);
    return (sel == REG_PSTACK) || (sel == REG_RSTACK);
  endfunction

endpackage

// File: rtl/regfile_sequencer.sv
// Multi-cycle READ/CAPTURE/EXEC/WRITE controller owning all register_file control ports
// and feeding registered operands to an external ALU.
module regfile_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [3:0]           op_a_sel,
  input  logic [3:0]           op_b_sel,
  input  logic                 op_rd_a,
  input  logic                 op_rd_b,
  input  logic                 op_wr_a,
  input  logic                 op_wr_psr,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic [WIDTH-1:0]     alu_flags,
  output logic [3:0]           rf_a_sel,
  output logic [3:0]           rf_b_sel,
  output logic                 rf_a_rd_en,
  output logic                 rf_b_rd_en,
  output logic                 rf_a_wr_en,
  output logic [WIDTH-1:0]     rf_a_wr_data,
  output logic                 rf_psr_wr_en,
  output logic [WIDTH-1:0]     rf_psr_wr_data,
  input  logic [WIDTH-1:0]     rf_a_rd_data,
  input  logic [WIDTH-1:0]     rf_b_rd_data,
  input  logic [WIDTH-1:0]     rf_psr_rd_data,
  output logic                 retired,
  output logic [CNT_WIDTH-1:0] retired_count
);

  logic [2:0]           r_state;
  logic [3:0]           r_a_sel;
  logic [3:0]           r_b_sel;
  logic                 r_rd_a;
  logic                 r_rd_b;
  logic                 r_wr_a;
  logic                 r_wr_psr;
  logic [WIDTH-1:0]     r_alu_a;
  logic [WIDTH-1:0]     r_alu_b;
  logic                 r_alu_start;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_flags;
  logic [CNT_WIDTH-1:0] r_retired_count;

  logic w_same_stack;
  logic w_write_a;
  logic w_idle;

  // Both ports reading one stack must pop it once; B then reuses A's data.
  always_comb begin
    w_same_stack = r_rd_a && r_rd_b && (r_a_sel == r_b_sel) && is_stack(r_a_sel);
    w_write_a    = (r_state == S_WRITE) && r_wr_a;
    w_idle       = (r_state == S_IDLE);
  end

  always_comb begin
    op_ready       = w_idle;
    rf_a_sel       = w_idle ? 4'h0 : r_a_sel;
    rf_b_sel       = w_idle ? 4'h0 : r_b_sel;
    rf_a_rd_en     = (r_state == S_READ) && r_rd_a;
    rf_b_rd_en     = (r_state == S_READ) && r_rd_b && !w_same_stack;
    rf_a_wr_en     = w_write_a;
    rf_psr_wr_en   = (r_state == S_WRITE) && r_wr_psr && !(r_wr_a && (r_a_sel == REG_PSR));
    rf_psr_wr_data = r_flags;
    retired        = (r_state == S_WRITE);
    alu_a          = r_alu_a;
    alu_b          = r_alu_b;
    alu_start      = r_alu_start;
    retired_count  = r_retired_count;
    // register_file loads PSR from A's write data whenever A selects it; echo PSR back
    // so that implicit write is harmless unless this is a real write to PSR.
    if ((rf_a_sel == REG_PSR) && !w_write_a) begin
      rf_a_wr_data = rf_psr_rd_data;
    end else begin
      rf_a_wr_data = r_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_a_sel         <= 4'h0;
      r_b_sel         <= 4'h0;
      r_rd_a          <= 1'b0;
      r_rd_b          <= 1'b0;
      r_wr_a          <= 1'b0;
      r_wr_psr        <= 1'b0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_start     <= 1'b0;
      r_result        <= '0;
      r_flags         <= '0;
      r_retired_count <= '0;
    end else begin
      r_alu_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_a_sel  <= op_a_sel;
            r_b_sel  <= op_b_sel;
            r_rd_a   <= op_rd_a;
            r_rd_b   <= op_rd_b;
            r_wr_a   <= op_wr_a;
            r_wr_psr <= op_wr_psr;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_alu_a     <= r_rd_a ? rf_a_rd_data : '0;
          if (!r_rd_b) begin
            r_alu_b <= '0;
          end else if (w_same_stack) begin
            r_alu_b <= rf_a_rd_data;
          end else begin
            r_alu_b <= rf_b_rd_data;
          end
          r_alu_start <= 1'b1;
          r_state     <= S_EXEC;
        end
        S_EXEC: begin
          if (alu_done) begin
            r_result <= alu_result;
            r_flags  <= alu_flags;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_retired_count <= r_retired_count + CNT_WIDTH'(1);
          r_state         <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
